// File: rtl/key_hold_pkg.sv
// Shared types and constants for the multi-channel key hold timer.
package key_hold_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ch_state_t;

    localparam int EVT_CNT_W     = 4;
    localparam int DEF_HOLD_BASE = 38_000_000;

endpackage

// File: rtl/hold_period_div.sv
// Iterative restoring divider: HOLD_BASE / den, one quotient bit per cycle, CNT_W cycles.
// done and quo are combinational on the final iteration so the caller can latch on the same edge.
module hold_period_div
    import key_hold_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int SPEED_W   = 5,
    parameter int HOLD_BASE = DEF_HOLD_BASE
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [SPEED_W-1:0] den,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   quo,
    output logic [SPEED_W-1:0] den_q
);

    localparam int STEP_W = $clog2(CNT_W);

    logic [STEP_W-1:0]  step;
    logic [SPEED_W-1:0] rem;
    logic [CNT_W-1:0]   quo_r;
    logic [SPEED_W-1:0] den_r;
    logic [SPEED_W:0]   rem_sh;
    logic [SPEED_W-1:0] diff;
    logic               ge;
    logic [SPEED_W-1:0] rem_nx;
    logic [CNT_W-1:0]   quo_nx;

    // The remainder never reaches den, so SPEED_W bits suffice and the subtraction can wrap safely.
    always_comb begin
        rem_sh = {rem, quo_r[CNT_W-1]};
        ge     = rem_sh >= {1'b0, den_r};
        diff   = rem_sh[SPEED_W-1:0] - den_r;
        rem_nx = ge ? diff : rem_sh[SPEED_W-1:0];
        quo_nx = {quo_r[CNT_W-2:0], ge};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            busy  <= 1'b0;
            step  <= '0;
            rem   <= '0;
            quo_r <= '0;
            den_r <= SPEED_W'(1);
        end else if (!busy) begin
            if (start) begin
                busy  <= 1'b1;
                step  <= STEP_W'(CNT_W - 1);
                rem   <= '0;
                quo_r <= CNT_W'(HOLD_BASE);
                den_r <= den;
            end
        end else begin
            rem   <= rem_nx;
            quo_r <= quo_nx;
            step  <= step - STEP_W'(1);
            if (step == '0) busy <= 1'b0;
        end
    end

    assign done  = busy && (step == '0);
    assign quo   = quo_nx;
    assign den_q = den_r;

endmodule

// File: rtl/key_hold_timer.sv
// Multi-channel key hold timer: each key event holds its channel high for HOLD_BASE/speedup cycles.
// Optional AUTOREPEAT_EN: a channel whose key_level stays high re-arms and re-fires at expiry.
module key_hold_timer
    import key_hold_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  CNT_W     = 32,
    parameter int  SPEED_W   = 5,
    parameter int  HOLD_BASE = DEF_HOLD_BASE,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        key_valid,
    input  logic [CH_W-1:0]             key_ch,
    input  logic [NUM_CH-1:0]           key_level,
    input  logic [SPEED_W-1:0]          speedup,
    output logic [NUM_CH-1:0]           hold,
    output logic [NUM_CH-1:0]           fire,
    output logic [EVT_CNT_W*NUM_CH-1:0] event_cnt,
    output logic [CNT_W-1:0]            period,
    output logic                        div_busy
);

    logic [SPEED_W-1:0] eff_speed;
    logic [SPEED_W-1:0] speedup_q;
    logic               div_start;
    logic               div_done;
    logic [CNT_W-1:0]   div_quo;
    logic [SPEED_W-1:0] div_den;

    assign eff_speed = (speedup == '0) ? SPEED_W'(1) : speedup;
    assign div_start = !div_busy && (eff_speed != speedup_q);

    hold_period_div #(
        .CNT_W    (CNT_W),
        .SPEED_W  (SPEED_W),
        .HOLD_BASE(HOLD_BASE)
    ) u_div (
        .clock (clock),
        .resetn(resetn),
        .start (div_start),
        .den   (eff_speed),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo),
        .den_q (div_den)
    );

    // A zero quotient would give a zero-length hold, so clamp to one cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            period    <= CNT_W'(HOLD_BASE);
            speedup_q <= SPEED_W'(1);
        end else if (div_done) begin
            period    <= (div_quo == '0) ? CNT_W'(1) : div_quo;
            speedup_q <= div_den;
        end
    end

`ifndef AUTOREPEAT_EN
    logic unused_key_level;
    assign unused_key_level = ^key_level;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t            st, st_nx;
        logic [CNT_W-1:0]     cnt, cnt_nx;
        logic [EVT_CNT_W-1:0] ec, ec_nx;
        logic                 fire_q, fire_nx;
        logic                 ev;

        assign ev = key_valid && (key_ch == CH_W'(i));

        always_ff @(posedge clock) begin
            if (!resetn) begin
                st     <= IDLE;
                cnt    <= '0;
                ec     <= '0;
                fire_q <= 1'b0;
            end else begin
                st     <= st_nx;
                cnt    <= cnt_nx;
                ec     <= ec_nx;
                fire_q <= fire_nx;
            end
        end

        always_comb begin
            st_nx   = st;
            cnt_nx  = cnt;
            ec_nx   = ec;
            fire_nx = 1'b0;
            case (st)
                IDLE: begin
                    if (ev) begin
                        st_nx   = HOLD;
                        cnt_nx  = period - CNT_W'(1);
                        ec_nx   = ec + EVT_CNT_W'(1);
                        fire_nx = 1'b1;
                    end
                end
                HOLD: begin
                    // A retrigger landing on the expiry cycle wins, so hold never glitches low.
                    if (ev) begin
                        cnt_nx = period - CNT_W'(1);
                        ec_nx  = ec + EVT_CNT_W'(1);
                    end else if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else begin
`ifdef AUTOREPEAT_EN
                        if (key_level[i]) begin
                            cnt_nx  = period - CNT_W'(1);
                            fire_nx = 1'b1;
                        end else begin
                            st_nx = IDLE;
                        end
`else
                        st_nx = IDLE;
`endif
                    end
                end
                default: st_nx = IDLE;
            endcase
        end

        assign hold[i]                          = (st == HOLD);
        assign fire[i]                          = fire_q;
        assign event_cnt[i*EVT_CNT_W+:EVT_CNT_W] = ec;
    end

endmodule
